// File: rtl/requant_sched_pkg.sv
// Shared definitions for the requantize scheduler: FSM state encoding, default widths
// and the Nquant validity rule.
package requant_sched_pkg;

  localparam int NCH_DEF  = 4;
  localparam int DW_DEF   = 18;
  localparam int QW_DEF   = 5;
  localparam int LAT_DEF  = 2;
  localparam int QDEF_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Nquant must select at least one bit and stay inside the sample width.
  function automatic logic nquant_ok(input int q, input int dw);
    return (q != 0) && (q <= dw - 1);
  endfunction

endpackage

// File: rtl/requant_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = (int'(ptr) + i) % NCH;
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = CHW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/requant_sched.sv
// Time-shares one requantize datapath between NCH requesters: round-robin grant,
// single endatain pulse, fixed-latency wait, then a valid/ready result tagged by channel.
module requant_sched
  import requant_sched_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int DW   = DW_DEF,
  parameter int QW   = QW_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int QDEF = QDEF_DEF,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] req_data,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [QW-1:0]     cfg_nquant,
  output logic [NCH-1:0]    gnt,
  output logic [DW-1:0]     rq_datain,
  output logic [QW-1:0]     rq_nquant,
  output logic              rq_endatain,
  input  logic [DW-1:0]     rq_dataout,
  output logic              res_valid,
  output logic [CHW-1:0]    res_ch,
  output logic [DW-1:0]     res_data,
  input  logic              res_ready,
  output logic              busy
);

  localparam int CW = $clog2(LAT + 1);

  state_t          state_reg, state_next;
  logic [CHW-1:0]  ptr_reg, ch_reg, res_ch_reg;
  logic [DW-1:0]   data_reg, res_data_reg;
  logic [QW-1:0]   q_reg;
  logic [CW-1:0]   cnt_reg;
  logic [QW-1:0]   nquant_reg [NCH];
  logic [NCH-1:0]  wr_en;
  logic [NCH-1:0]  arb_gnt;
  logic [CHW-1:0]  arb_idx;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_wr
    assign wr_en[gi] = cfg_we && (int'(cfg_ch) == gi) && nquant_ok(int'(cfg_nquant), DW);
  end

  // A same-edge write to the granted channel lands after the grant latched the old value.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset)         nquant_reg[i] <= QW'(QDEF);
      else if (wr_en[i]) nquant_reg[i] <= cfg_nquant;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_reg == CW'(1)) state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= CHW'(NCH - 1);
      ch_reg       <= '0;
      data_reg     <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      res_data_reg <= '0;
      res_ch_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (|req) begin
          data_reg <= req_data[int'(arb_idx)*DW +: DW];
          q_reg    <= nquant_reg[arb_idx];
          ch_reg   <= arb_idx;
        end
        ISSUE: cnt_reg <= CW'(LAT);
        WAIT: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            res_data_reg <= rq_dataout;
            res_ch_reg   <= ch_reg;
          end
        end
        HOLD: if (res_ready) ptr_reg <= ch_reg;
        default: ;
      endcase
    end
  end

  assign gnt         = (state_reg == IDLE && !reset) ? arb_gnt : '0;
  assign rq_endatain = (state_reg == ISSUE);
  assign rq_datain   = (state_reg == ISSUE || state_reg == WAIT) ? data_reg : '0;
  assign rq_nquant   = (state_reg == ISSUE || state_reg == WAIT) ? q_reg : '0;
  assign res_valid   = (state_reg == HOLD);
  assign res_ch      = res_ch_reg;
  assign res_data    = res_data_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_requant_sched.sv
// Bench for requant_sched: table of directed operations, reset/abort sequences, a held
// all-channel round-robin run and randomized operations against a behavioural model.
module tb_requant_sched;

  localparam int NCH  = 4;
  localparam int DW   = 18;
  localparam int QW   = 5;
  localparam int LAT  = 2;
  localparam int QDEF = 8;
  localparam int CHW  = $clog2(NCH);

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] req_data;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [QW-1:0]     cfg_nquant;
  logic [NCH-1:0]    gnt;
  logic [DW-1:0]     rq_datain;
  logic [QW-1:0]     rq_nquant;
  logic              rq_endatain;
  logic [DW-1:0]     rq_dataout;
  logic              res_valid;
  logic [CHW-1:0]    res_ch;
  logic [DW-1:0]     res_data;
  logic              res_ready;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int nq_m [NCH];
  int last_m;

  always #5 clock = ~clock;

  requant_sched #(.NCH(NCH), .DW(DW), .QW(QW), .LAT(LAT), .QDEF(QDEF)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_nquant(cfg_nquant), .gnt(gnt),
    .rq_datain(rq_datain), .rq_nquant(rq_nquant), .rq_endatain(rq_endatain),
    .rq_dataout(rq_dataout), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  // Toy requantize stand-in: keeps the top bits selected by Nquant, salted with Nquant.
  function automatic logic [DW-1:0] rq_model(input logic [DW-1:0] d, input logic [QW-1:0] q);
    int sh;
    sh = DW - 1 - int'(q);
    if (sh < 0) sh = 0;
    return DW'(d >> sh) ^ DW'(q);
  endfunction

  // Datapath with LAT cycles of latency; outside a valid slot it returns noise.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= rq_endatain ? rq_model(rq_datain, rq_nquant) : DW'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rq_dataout = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) nq_m[i] = QDEF;
    last_m = NCH - 1;
  endtask

  task automatic model_cfg(input int ch, input int val);
    if (ch < NCH && val != 0 && val <= DW - 1) nq_m[ch] = val;
  endtask

  function automatic int model_pick(input logic [NCH-1:0] mask);
    int c;
    for (int i = 1; i <= NCH; i++) begin
      c = (last_m + i) % NCH;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; req = '0; cfg_we = 1'b0; res_ready = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_ctrl", {gnt, rq_endatain, res_valid, res_ch, busy}, 0);
    chk("rst_data", rq_datain | res_data, 0);
    chk("rst_nquant", rq_nquant, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int ch, input int val);
    @(posedge clock); #1;
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_nquant = QW'(val);
    @(posedge clock); #1;
    cfg_we = 1'b0;
    model_cfg(ch, val);
  endtask

  // One full operation from the IDLE grant cycle T through the handshake.
  task automatic op(input logic [NCH-1:0] mask, input logic [DW-1:0] data, input int stall,
                    input bit cfg_en, input int cch, input int cval,
                    input int exp_ch, input int exp_q);
    logic [DW-1:0] exp_res;
    int lat, pulses, bad;
    @(posedge clock); #1;
    for (int c = 0; c < NCH; c++) req_data[c*DW +: DW] = DW'($urandom);
    req_data[exp_ch*DW +: DW] = data;
    req = mask;
    res_ready = (stall == 0);
    if (cfg_en) begin cfg_we = 1'b1; cfg_ch = CHW'(cch); cfg_nquant = QW'(cval); end
    @(negedge clock);
    chk("gnt", gnt, 32'(1) << exp_ch);
    chk("busy_T", busy, 0);
    chk("endatain_T", rq_endatain, 0);
    @(posedge clock); #1;
    req = '0; cfg_we = 1'b0;
    if (cfg_en) model_cfg(cch, cval);
    exp_res = rq_model(data, QW'(exp_q));
    @(negedge clock);
    chk("endatain", rq_endatain, 1);
    chk("rq_nquant", rq_nquant, exp_q);
    chk("rq_datain", rq_datain, data);
    chk("gnt_issue", {gnt, busy}, 1);
    lat = 1; pulses = 0;
    while (!res_valid && lat < LAT + 10) begin
      @(posedge clock); #1;
      @(negedge clock);
      lat++;
      if (rq_endatain) pulses++;
    end
    chk("latency", lat, LAT + 2);
    chk("extra_pulse", pulses, 0);
    chk("res_ch", res_ch, exp_ch);
    chk("res_data", res_data, exp_res);
    if (stall > 0) begin
      bad = 0;
      req = mask;
      for (int s = 1; s < stall; s++) begin
        @(posedge clock); #1;
        @(negedge clock);
        if (!res_valid || res_data !== exp_res || res_ch !== CHW'(exp_ch) ||
            gnt !== '0 || rq_endatain) bad++;
      end
      chk("hold_stable", bad, 0);
      @(posedge clock); #1;
      req = '0; res_ready = 1'b1;
      @(negedge clock);
      chk("hold_last", {res_valid, gnt}, 32'(1) << NCH);
    end
    @(posedge clock); #1;
    res_ready = 1'b0;
    @(negedge clock);
    chk("back_idle", {busy, res_valid}, 0);
    last_m = exp_ch;
    $display("op ch=%0d q=%0d data=%05h res=%05h stall=%0d lat=%0d", exp_ch, exp_q, data,
             exp_res, stall, lat);
  endtask

  // Start an operation, then reset for two cycles while it is in WAIT.
  task automatic abort_op(input logic [NCH-1:0] mask, input int exp_ch);
    int bad;
    @(posedge clock); #1;
    req = mask; res_ready = 1'b1;
    @(negedge clock);
    chk("abort_gnt", gnt, 32'(1) << exp_ch);
    @(posedge clock); #1;
    req = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_ctrl", {gnt, rq_endatain, res_valid, res_ch, busy}, 0);
    chk("abort_data", rq_datain | res_data, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (res_valid || busy) bad++;
    end
    chk("abort_no_result", bad, 0);
    $display("abort ch=%0d during WAIT", exp_ch);
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    logic [DW-1:0]  data;
    int             stall;
    bit             cfg_en;
    int             cch;
    int             cval;
    int             exp_ch;
    int             exp_q;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int q[$];
    logic [NCH-1:0] gv[$];
    int wait_cnt;
    vecs[0]  = '{4'b0001, 18'b1000_0000_0000_0001_10, 0, 1'b0, 0, 0, 0, 2};
    vecs[1]  = '{4'b0010, 18'h1f0f0, 0, 1'b1, 1, 17, 1, 7};
    vecs[2]  = '{4'b0010, 18'h2a5a5, 0, 1'b1, 1, 0, 1, 17};
    vecs[3]  = '{4'b0010, 18'h05555, 0, 1'b1, 1, 18, 1, 17};
    vecs[4]  = '{4'b0010, 18'h3ffff, 0, 1'b0, 0, 0, 1, 17};
    vecs[5]  = '{4'b0011, 18'h12345, 10, 1'b0, 0, 0, 0, 2};
    vecs[6]  = '{4'b1001, 18'h0abcd, 0, 1'b0, 0, 0, 3, 8};
    vecs[7]  = '{4'b1001, 18'h3c3c3, 2, 1'b0, 0, 0, 0, 2};
    vecs[8]  = '{4'b0100, 18'h00001, 0, 1'b1, 2, 31, 2, 8};
    vecs[9]  = '{4'b0100, 18'h20000, 1, 1'b1, 3, 1, 2, 8};
    vecs[10] = '{4'b1000, 18'h2ffff, 0, 1'b0, 0, 0, 3, 1};

    reset = 1'b1; req = '0; req_data = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_nquant = '0; res_ready = 1'b0;
    model_reset();
    do_reset();
    cfg_write(0, 2);
    cfg_write(1, 7);

    foreach (vecs[i])
      op(vecs[i].mask, vecs[i].data, vecs[i].stall, vecs[i].cfg_en, vecs[i].cch,
         vecs[i].cval, vecs[i].exp_ch, vecs[i].exp_q);

    // Reset mid-run restores Nquant defaults and the ch0-first pointer.
    abort_op(4'b0100, 2);
    op(4'b0001, 18'h1beef, 0, 1'b0, 0, 0, 0, QDEF);
    abort_op(4'b0100, 2);
    op(4'b0110, 18'h0cafe, 0, 1'b0, 0, 0, 1, QDEF);

    // All channels requesting continuously.
    do_reset();
    @(posedge clock); #1;
    for (int c = 0; c < NCH; c++) req_data[c*DW +: DW] = DW'($urandom);
    req = '1; res_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      if (gnt !== '0) begin q.push_back(c); gv.push_back(gnt); end
      @(posedge clock); #1;
    end
    req = '0;
    chk("rr_count", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      chk("rr_order", gv[i], 32'(1) << (i % NCH));
      if (i > 0) chk("rr_gap", q[i] - q[i-1], LAT + 3);
    end
    wait_cnt = 0;
    while (busy && wait_cnt < 20) begin @(posedge clock); #1; wait_cnt++; end
    chk("rr_drain", busy, 0);
    $display("rr run grants=%0d", q.size());
    last_m = 0;

    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [NCH-1:0] m;
      int ec, cch, cval;
      bit ce;
      m    = NCH'($urandom_range(1, (1 << NCH) - 1));
      ec   = model_pick(m);
      ce   = 1'($urandom_range(0, 1));
      cch  = $urandom_range(0, NCH - 1);
      cval = $urandom_range(0, (1 << QW) - 1);
      op(m, DW'($urandom), $urandom_range(0, 3), ce, cch, cval, ec, nq_m[ec]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
